// File: rtl/calc_pkg.sv
// Shared definitions for the calculator datapath and its controller FSM:
// op-code encoding, register-file geometry and the multiplier state type.
package calc_pkg;

   localparam logic [2:0] OP_NONE = 3'b000;
   localparam logic [2:0] OP_ADD  = 3'b001;
   localparam logic [2:0] OP_SUB  = 3'b010;
   localparam logic [2:0] OP_MUL  = 3'b011;
   localparam logic [2:0] OP_XOR  = 3'b100;

   localparam int         RF_DEPTH  = 8;
   localparam logic [2:0] ZERO_ADDR = 3'b111;

   typedef enum logic {
      MUL_IDLE,
      MUL_RUN
   } mul_state_t;

   function automatic logic isLegalOp(input logic [2:0] op);
      return (op != OP_NONE) && (op <= OP_XOR);
   endfunction

endpackage

// File: rtl/calc_seq_mul.sv
// Iterative shift-add multiplier, one multiplier bit per clock.
// busy spans exactly W cycles from the start edge; done flags the final cycle.
module calc_seq_mul
   import calc_pkg::*;
#(
   parameter int W = 8
) (
   input  logic           CLK,
   input  logic           RST_n,
   input  logic           start,
   input  logic [W-1:0]   a,
   input  logic [W-1:0]   b,
   output logic           busy,
   output logic           done,
   output logic [2*W-1:0] product
);

   localparam int CW = $clog2(W + 1);

   mul_state_t       state, stateNext;
   logic [CW-1:0]    bitCnt;
   logic [W-1:0]     mplier;
   logic [2*W-1:0]   mcand;
   logic [2*W-1:0]   acc;

   always_ff @(posedge CLK or negedge RST_n) begin
      if (!RST_n) state <= MUL_IDLE;
      else        state <= stateNext;
   end

   always_comb begin
      stateNext = state;
      busy      = (state == MUL_RUN);
      done      = 1'b0;
      case (state)
         MUL_IDLE: if (start) stateNext = MUL_RUN;
         MUL_RUN: begin
            if (bitCnt == CW'(W)) begin
               done      = 1'b1;
               stateNext = MUL_IDLE;
            end
         end
         default: stateNext = MUL_IDLE;
      endcase
   end

   // Bit 0 is folded in on the start edge so the product is complete
   // (and registered) by the last busy cycle.
   always_ff @(posedge CLK or negedge RST_n) begin
      if (!RST_n) begin
         acc    <= '0;
         mplier <= '0;
         mcand  <= '0;
         bitCnt <= '0;
      end else if (state == MUL_IDLE && start) begin
         acc    <= a[0] ? {{W{1'b0}}, b} : '0;
         mplier <= a >> 1;
         mcand  <= {{W{1'b0}}, b} << 1;
         bitCnt <= CW'(1);
      end else if (state == MUL_RUN && !done) begin
         if (mplier[0]) acc <= acc + mcand;
         mplier <= mplier >> 1;
         mcand  <= mcand << 1;
         bitCnt <= bitCnt + CW'(1);
      end
   end

   assign product = acc;

endmodule

// File: rtl/calc_datapath.sv
// Calculator datapath: 8-entry register file, single-cycle ADD/SUB/XOR,
// iterative MUL, and the registered result/flag outputs.
module calc_datapath
   import calc_pkg::*;
#(
   parameter int W = 8
) (
   input  logic         CLK,
   input  logic         RST_n,
   input  logic [W-1:0] Din,
   input  logic         WE,
   input  logic [2:0]   W1,
   input  logic [2:0]   num_R1,
   input  logic [2:0]   num_R2,
   input  logic [2:0]   MS,
   output logic [W-1:0] Dout1,
   output logic [W-1:0] Dout2,
   output logic [W-1:0] Result,
   output logic         Busy,
   output logic         Valid,
   output logic         Ovf,
   output logic         Zero,
   output logic         Err
);

   logic [W-1:0]   rf [RF_DEPTH];
   logic [2:0]     msQ;
   logic [2:0]     destQ;
   logic           start;
   logic           aluOp;
   logic           mulStart;
   logic           mulDone;
   logic [2*W-1:0] product;
   logic [W:0]     aluWide;
   logic [W-1:0]   aluRes;
   logic           aluOvf;
   logic           wbEn;
   logic [2:0]     wbAddr;
   logic [W-1:0]   wbData;

   assign Dout1 = (num_R1 == ZERO_ADDR) ? '0 : rf[num_R1];
   assign Dout2 = (num_R2 == ZERO_ADDR) ? '0 : rf[num_R2];

   // Only the 0->nonzero transition of MS launches an op, and never while busy.
   assign start    = (MS != OP_NONE) && (msQ == OP_NONE) && !Busy;
   assign aluOp    = start && (MS == OP_ADD || MS == OP_SUB || MS == OP_XOR);
   assign mulStart = start && (MS == OP_MUL);

   calc_seq_mul #(.W(W)) u_mul (
      .CLK     (CLK),
      .RST_n   (RST_n),
      .start   (mulStart),
      .a       (Dout1),
      .b       (Dout2),
      .busy    (Busy),
      .done    (mulDone),
      .product (product)
   );

   always_comb begin
      aluWide = '0;
      aluRes  = '0;
      aluOvf  = 1'b0;
      case (MS)
         OP_ADD: begin
            aluWide = {1'b0, Dout1} + {1'b0, Dout2};
            aluRes  = aluWide[W-1:0];
            aluOvf  = aluWide[W];
         end
         OP_SUB: begin
            aluWide = {1'b0, Dout1} - {1'b0, Dout2};
            aluRes  = aluWide[W-1:0];
            aluOvf  = aluWide[W];
         end
         OP_XOR:  aluRes = Dout1 ^ Dout2;
         default: aluRes = '0;
      endcase
   end

   always_comb begin
      wbEn   = 1'b0;
      wbAddr = W1;
      wbData = aluRes;
      if (aluOp) begin
         wbEn = 1'b1;
      end else if (mulDone) begin
         wbEn   = 1'b1;
         wbAddr = destQ;
         wbData = product[W-1:0];
      end
   end

   // The external write takes priority when both target the same entry.
   always_ff @(posedge CLK or negedge RST_n) begin
      if (!RST_n) begin
         for (int i = 0; i < RF_DEPTH; i++) rf[i] <= '0;
      end else begin
         for (int i = 0; i < RF_DEPTH; i++) begin
            if (3'(i) != ZERO_ADDR) begin
               if (WE && W1 == 3'(i))              rf[i] <= Din;
               else if (wbEn && wbAddr == 3'(i))   rf[i] <= wbData;
            end
         end
      end
   end

   always_ff @(posedge CLK or negedge RST_n) begin
      if (!RST_n) begin
         msQ    <= OP_NONE;
         destQ  <= '0;
         Result <= '0;
         Ovf    <= 1'b0;
         Valid  <= 1'b0;
         Err    <= 1'b0;
      end else begin
         msQ   <= MS;
         Valid <= 1'b0;
         Err   <= 1'b0;
         if (start && !isLegalOp(MS)) Err <= 1'b1;
         if (mulStart) destQ <= W1;
         if (aluOp) begin
            Result <= aluRes;
            Ovf    <= aluOvf;
            Valid  <= 1'b1;
         end else if (mulDone) begin
            Result <= product[W-1:0];
            Ovf    <= |product[2*W-1:W];
            Valid  <= 1'b1;
         end
      end
   end

   assign Zero = (Result == '0);

endmodule
